id_ex_operand_stage: RTL and testbench

//  ID/EX pipeline register feeding the ALU: one-entry valid/ready buffer holding decoded operands, then

---
 rtl/riscv_pkg.sv | 26 ++
 rtl/id_ex_operand_stage_fwd_mux.sv | 34 +++
 rtl/id_ex_operand_stage.sv | 143 ++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared datapath widths, ALU op encodings and operand-select constants for the
// integer pipeline.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int REGW = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLL  = 4'b0010,
        ALU_SLT  = 4'b0011,
        ALU_SLTU = 4'b0100,
        ALU_XOR  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_OR   = 4'b1000,
        ALU_AND  = 4'b1001
    } aluOpT;

    localparam logic OPA_RS1 = 1'b0;
    localparam logic OPA_PC  = 1'b1;
    localparam logic OPB_RS2 = 1'b0;
    localparam logic OPB_IMM = 1'b1;

endpackage

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Per-operand forwarding mux: picks EX/MEM, then MEM/WB, then the stored register
// value. The MEM/WB hit flag is exported so the stage can snoop while stalled.
module fwd_mux #(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter int REGW = riscv_pkg::REGW
) (
    input  logic [REGW-1:0] srcAddr,
    input  logic [XLEN-1:0] srcData,
    input  logic            exMemRegWrite,
    input  logic [REGW-1:0] exMemRd,
    input  logic [XLEN-1:0] exMemResult,
    input  logic            memWbRegWrite,
    input  logic [REGW-1:0] memWbRd,
    input  logic [XLEN-1:0] memWbResult,
    output logic [XLEN-1:0] effData,
    output logic            memWbHit
);

    logic exMemHit;

    // x0 is hardwired zero, so a write targeting it must never be forwarded.
    assign exMemHit = exMemRegWrite && (exMemRd != '0) && (exMemRd == srcAddr);
    assign memWbHit = memWbRegWrite && (memWbRd != '0) && (memWbRd == srcAddr);

    always_comb begin
        effData = srcData;
        if (exMemHit) begin
            effData = exMemResult;
        end else if (memWbHit) begin
            effData = memWbResult;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register: one-entry valid/ready buffer of decoded operands that
// drives the ALU with EX/MEM and MEM/WB forwarding and a saturating stall counter.
module id_ex_operand_stage #(
    parameter int XLEN   = riscv_pkg::XLEN,
    parameter int REGW   = riscv_pkg::REGW,
    parameter int STALLW = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inValid,
    output logic              inReady,
    input  logic [REGW-1:0]   rs1Addr,
    input  logic [REGW-1:0]   rs2Addr,
    input  logic [XLEN-1:0]   rs1Data,
    input  logic [XLEN-1:0]   rs2Data,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   imm,
    input  logic              opASel,
    input  logic              opBSel,
    input  logic [3:0]        aluSelIn,
    input  logic [REGW-1:0]   rdIn,
    input  logic              regWriteIn,
    input  logic              exMemRegWrite,
    input  logic [REGW-1:0]   exMemRd,
    input  logic [XLEN-1:0]   exMemResult,
    input  logic              memWbRegWrite,
    input  logic [REGW-1:0]   memWbRd,
    input  logic [XLEN-1:0]   memWbResult,
    input  logic              flush,
    output logic              outValid,
    input  logic              outReady,
    output logic [XLEN-1:0]   opA,
    output logic [XLEN-1:0]   opB,
    output logic [3:0]        aluOutSel,
    output logic [REGW-1:0]   rdOut,
    output logic              regWriteOut,
    output logic [STALLW-1:0] stallCount
);

    import riscv_pkg::*;

    // Handshake: a transfer happens on a rising edge where valid && ready are both
    // high; valid never depends on ready, and ready may depend on downstream ready.

    logic              validQ;
    logic [REGW-1:0]   rs1AddrQ, rs2AddrQ;
    logic [XLEN-1:0]   rs1DataQ, rs2DataQ;
    logic [XLEN-1:0]   pcQ, immQ;
    logic              opASelQ, opBSelQ;
    logic [3:0]        aluSelQ;
    logic [REGW-1:0]   rdQ;
    logic              regWriteQ;
    logic [STALLW-1:0] stallCntQ;

    logic              capture;
    logic [XLEN-1:0]   rs1Eff, rs2Eff;
    logic              rs1MemWbHit, rs2MemWbHit;

    assign inReady = !validQ || outReady;
    assign capture = inValid && inReady && !flush;

    fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_fwdRs1 (
        .srcAddr       (rs1AddrQ),
        .srcData       (rs1DataQ),
        .exMemRegWrite (exMemRegWrite),
        .exMemRd       (exMemRd),
        .exMemResult   (exMemResult),
        .memWbRegWrite (memWbRegWrite),
        .memWbRd       (memWbRd),
        .memWbResult   (memWbResult),
        .effData       (rs1Eff),
        .memWbHit      (rs1MemWbHit)
    );

    fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_fwdRs2 (
        .srcAddr       (rs2AddrQ),
        .srcData       (rs2DataQ),
        .exMemRegWrite (exMemRegWrite),
        .exMemRd       (exMemRd),
        .exMemResult   (exMemResult),
        .memWbRegWrite (memWbRegWrite),
        .memWbRd       (memWbRd),
        .memWbResult   (memWbResult),
        .effData       (rs2Eff),
        .memWbHit      (rs2MemWbHit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            validQ    <= 1'b0;
            rs1AddrQ  <= '0;
            rs2AddrQ  <= '0;
            rs1DataQ  <= '0;
            rs2DataQ  <= '0;
            pcQ       <= '0;
            immQ      <= '0;
            opASelQ   <= OPA_RS1;
            opBSelQ   <= OPB_RS2;
            aluSelQ   <= ALU_ADD;
            rdQ       <= '0;
            regWriteQ <= 1'b0;
            stallCntQ <= '0;
        end else begin
            if (flush) begin
                validQ <= 1'b0;
            end else if (capture) begin
                validQ    <= 1'b1;
                rs1AddrQ  <= rs1Addr;
                rs2AddrQ  <= rs2Addr;
                rs1DataQ  <= rs1Data;
                rs2DataQ  <= rs2Data;
                pcQ       <= pc;
                immQ      <= imm;
                opASelQ   <= opASel;
                opBSelQ   <= opBSel;
                aluSelQ   <= aluSelIn;
                rdQ       <= rdIn;
                regWriteQ <= regWriteIn;
            end else if (outReady) begin
                validQ <= 1'b0;
            end

            // A held entry absorbs MEM/WB writes so the value outlives the producer.
            if (validQ && !capture) begin
                if (rs1MemWbHit) rs1DataQ <= memWbResult;
                if (rs2MemWbHit) rs2DataQ <= memWbResult;
            end

            if (validQ && !outReady && (stallCntQ != '1)) begin
                stallCntQ <= stallCntQ + STALLW'(1);
            end
        end
    end

    assign outValid    = validQ;
    assign opA         = (opASelQ == OPA_PC)  ? pcQ  : rs1Eff;
    assign opB         = (opBSelQ == OPB_IMM) ? immQ : rs2Eff;
    assign aluOutSel   = aluSelQ;
    assign rdOut       = rdQ;
    assign regWriteOut = validQ && regWriteQ;
    assign stallCount  = stallCntQ;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Randomized and directed bench for id_ex_operand_stage: an issue process queues each
// accepted instruction, a negedge monitor compares outputs against an operand model.
module tb_id_ex_operand_stage;

  localparam int XLEN = 32;
  localparam int REGW = 5;
  localparam int STALLW = 4;
  localparam int STALL_MAX = (1 << STALLW) - 1;

  typedef struct {
    logic [REGW-1:0] rs1_addr;
    logic [REGW-1:0] rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] pc_v;
    logic [XLEN-1:0] imm_v;
    logic            a_sel;
    logic            b_sel;
    logic [3:0]      alu;
    logic [REGW-1:0] rd;
    logic            rw;
  } txn_t;

  logic clk, rst_n;
  logic inValid, inReady;
  logic [REGW-1:0] rs1Addr, rs2Addr, rdIn, exMemRd, memWbRd, rdOut;
  logic [XLEN-1:0] rs1Data, rs2Data, pc, imm, exMemResult, memWbResult, opA, opB;
  logic opASel, opBSel, regWriteIn, exMemRegWrite, memWbRegWrite, flush;
  logic outValid, outReady, regWriteOut;
  logic [3:0] aluSelIn, aluOutSel;
  logic [STALLW-1:0] stallCount;

  txn_t exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;
  int exp_stall = 0;
  bit cap_now = 0;
  bit held;
  txn_t head;
  logic [XLEN-1:0] exp_a, exp_b;

  id_ex_operand_stage #(.XLEN(XLEN), .REGW(REGW), .STALLW(STALLW)) dut (
    .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady),
    .rs1Addr(rs1Addr), .rs2Addr(rs2Addr), .rs1Data(rs1Data), .rs2Data(rs2Data),
    .pc(pc), .imm(imm), .opASel(opASel), .opBSel(opBSel), .aluSelIn(aluSelIn),
    .rdIn(rdIn), .regWriteIn(regWriteIn),
    .exMemRegWrite(exMemRegWrite), .exMemRd(exMemRd), .exMemResult(exMemResult),
    .memWbRegWrite(memWbRegWrite), .memWbRd(memWbRd), .memWbResult(memWbResult),
    .flush(flush), .outValid(outValid), .outReady(outReady),
    .opA(opA), .opB(opB), .aluOutSel(aluOutSel), .rdOut(rdOut),
    .regWriteOut(regWriteOut), .stallCount(stallCount)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural value of a source register as the ALU should see it this cycle.
  function automatic logic [XLEN-1:0] src_value(input logic [REGW-1:0] a, input logic [XLEN-1:0] known);
    if (a != 0 && exMemRegWrite && exMemRd == a) return exMemResult;
    if (a != 0 && memWbRegWrite && memWbRd == a) return memWbResult;
    return known;
  endfunction

  // monitor / scoreboard: compare, then advance the model by one cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_stall = 0;
      cap_now = 0;
    end else begin
      held = (exp_q.size() != 0);
      chk("outValid", outValid, held);
      chk("inReady", inReady, !held || outReady);
      chk("stallCount", stallCount, exp_stall);
      if (held) begin
        head = exp_q[0];
        exp_a = head.a_sel ? head.pc_v : src_value(head.rs1_addr, head.rs1_data);
        exp_b = head.b_sel ? head.imm_v : src_value(head.rs2_addr, head.rs2_data);
        chk("opA", opA, exp_a);
        chk("opB", opB, exp_b);
        chk("aluOutSel", aluOutSel, head.alu);
        chk("rdOut", rdOut, head.rd);
        chk("regWriteOut", regWriteOut, head.rw);
      end else begin
        chk("regWriteOut_idle", regWriteOut, 0);
      end
      if (held && !outReady && exp_stall < STALL_MAX) exp_stall++;
      cap_now = inValid && (!held || outReady) && !flush;
      if (flush) begin
        exp_q.delete();
      end else if (held && outReady) begin
        void'(exp_q.pop_front());
      end else if (held) begin
        if (memWbRegWrite && memWbRd != 0 && memWbRd == exp_q[0].rs1_addr) exp_q[0].rs1_data = memWbResult;
        if (memWbRegWrite && memWbRd != 0 && memWbRd == exp_q[0].rs2_addr) exp_q[0].rs2_data = memWbResult;
      end
    end
  end

  // issue: record each instruction the stage accepts
  always @(posedge clk) begin
    if (rst_n && cap_now) begin
      exp_q.push_back('{rs1Addr, rs2Addr, rs1Data, rs2Data, pc, imm, opASel, opBSel, aluSelIn, rdIn, regWriteIn});
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [REGW-1:0] a1, input logic [REGW-1:0] a2,
                           input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2,
                           input logic sa, input logic sb, input logic [3:0] op);
    rs1Addr = a1; rs2Addr = a2; rs1Data = d1; rs2Data = d2;
    pc = 32'h0000_1000 + XLEN'($urandom_range(0, 255) * 4);
    imm = $urandom; opASel = sa; opBSel = sb; aluSelIn = op;
    rdIn = REGW'($urandom_range(0, 31)); regWriteIn = 1'($urandom_range(0, 1));
    inValid = 1'b1;
  endtask

  task automatic fwd_off();
    exMemRegWrite = 0; exMemRd = 0; exMemResult = 0;
    memWbRegWrite = 0; memWbRd = 0; memWbResult = 0;
  endtask

  task automatic reset_checks();
    @(negedge clk);
    chk("rst_outValid", outValid, 0);
    chk("rst_aluOutSel", aluOutSel, 4'b0000);
    chk("rst_regWriteOut", regWriteOut, 0);
    chk("rst_rdOut", rdOut, 0);
    chk("rst_stallCount", stallCount, 0);
  endtask

  initial begin
    rst_n = 0; inValid = 0; outReady = 0; flush = 0;
    rs1Addr = 0; rs2Addr = 0; rs1Data = 0; rs2Data = 0; pc = 0; imm = 0;
    opASel = 0; opBSel = 0; aluSelIn = 0; rdIn = 0; regWriteIn = 0;
    fwd_off();
    repeat (2) step();
    reset_checks();
    step();
    rst_n = 1;

    // no hazard, back-to-back with full throughput
    outReady = 1;
    set_instr(5'd1, 5'd2, 32'd5, 32'd1, 0, 0, 4'b0000);
    step();
    set_instr(5'd4, 5'd6, 32'd7, 32'd4, 0, 0, 4'b0001);
    step();
    inValid = 0;
    repeat (2) step();

    // forwarding priority on a held entry
    outReady = 0;
    set_instr(5'd3, 5'd9, 32'd11, 32'd22, 0, 0, 4'b0101);
    step();
    inValid = 0;
    exMemRegWrite = 1; exMemRd = 3; exMemResult = 32'hAA;
    memWbRegWrite = 1; memWbRd = 3; memWbResult = 32'hBB;
    repeat (2) step();
    exMemRegWrite = 0;
    repeat (2) step();
    exMemRegWrite = 1; exMemRd = 0; memWbRd = 0;
    repeat (2) step();
    fwd_off();
    outReady = 1;
    step();

    // stall with snoop of a retiring producer, pc on operand A
    outReady = 0;
    set_instr(5'd8, 5'd7, 32'd3, 32'd99, 1, 0, 4'b0000);
    step();
    set_instr(5'd2, 5'd5, 32'd13, 32'd14, 0, 1, 4'b1000);
    memWbRegWrite = 1; memWbRd = 7; memWbResult = 32'd42;
    step();
    fwd_off();
    repeat (4) step();
    outReady = 1;
    step();
    inValid = 0;
    repeat (2) step();

    // flush beats capture and kills the held entry
    outReady = 0;
    set_instr(5'd10, 5'd11, 32'h1234, 32'h5678, 0, 0, 4'b0011);
    step();
    set_instr(5'd12, 5'd13, 32'hdead, 32'hbeef, 0, 0, 4'b0100);
    flush = 1;
    step();
    flush = 0; inValid = 0;
    outReady = 1;
    repeat (2) step();

    // stall counter saturation
    outReady = 0;
    set_instr(5'd1, 5'd1, 32'd1, 32'd1, 0, 0, 4'b0000);
    step();
    inValid = 0;
    repeat (20) step();
    outReady = 1;
    step();

    // randomized traffic with dense register aliasing
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        set_instr(REGW'($urandom_range(0, 3)), REGW'($urandom_range(0, 3)), $urandom, $urandom,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 9)));
      end else begin
        inValid = 0;
      end
      outReady = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 19) == 0);
      exMemRegWrite = 1'($urandom_range(0, 1)); exMemRd = REGW'($urandom_range(0, 3)); exMemResult = $urandom;
      memWbRegWrite = 1'($urandom_range(0, 1)); memWbRd = REGW'($urandom_range(0, 3)); memWbResult = $urandom;
      step();
    end
    inValid = 0; flush = 0; outReady = 1;
    fwd_off();
    repeat (2) step();

    // reset while an entry is held
    outReady = 0;
    set_instr(5'd4, 5'd5, 32'd44, 32'd55, 0, 0, 4'b0010);
    step();
    inValid = 0;
    step();
    rst_n = 0;
    step();
    reset_checks();
    step();
    rst_n = 1;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
